tomasulo_rob: RTL and testbench

// - Parametrised reorder buffer for the Tomasulo core: generalises the fixed 8-entry ROB array to configurable depth/widths.
// - Adds multi-port CDB write-back, in-order commit with a ready/valid handshake, and a full pipeline flush.
// - Sits between decode/dispatch (allocates tags), the functional units (CDB results) and the ARF/RAT (commit).

---
 rtl/tomasulo_rob.sv | 182 ++++++++++++++++++
 tb/tb_tomasulo_rob.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tomasulo_rob.sv
// -----------------------------------------------------------------------------
// tomasulo_rob -- parametrised reorder buffer for the Tomasulo core.
//
// Dispatch allocates entries at the tail and receives the granted tag. The
// functional units write results back over CDB_PORTS common-data-bus ports.
// Entries retire in order from the head through a ready/valid handshake toward
// the ARF/RAT. A flush discards every in-flight entry.
//
// Optional feature macro: CDB_BYPASS_EN
//   defined   : the rd lookup port also sees a CDB result written in the same
//               cycle (lowest-numbered port wins).
//   undefined : the rd lookup port reflects registered state only.
//
// Ports
//   clk1          clock; all state updates happen on its rising edge
//   rst           synchronous, active-high reset
//   alloc_valid   dispatch requests a new entry
//   alloc_dest    destination register of the allocated instruction
//   alloc_ready   an entry is available (= !full)
//   alloc_tag     tag granted this cycle (= tail pointer)
//   cdb_valid     per-port result valid
//   cdb_tag       per-port result tag; port p at [p*TAG_W +: TAG_W]
//   cdb_data      per-port result data; port p at [p*DATA_W +: DATA_W]
//   commit_valid  head entry is done and may retire
//   commit_ready  ARF/RAT accepts the retirement
//   commit_tag    head tag
//   commit_dest   head destination register
//   commit_data   head result
//   rd_tag        operand lookup tag from dispatch
//   rd_ready      looked-up entry is valid and done
//   rd_data       looked-up entry data
//   flush         discard all in-flight entries
//   count         occupied entries (0..ROB_DEPTH)
//   empty, full   count==0 / count==ROB_DEPTH
// -----------------------------------------------------------------------------
module tomasulo_rob #(
  parameter int ROB_DEPTH = 8,
  parameter int TAG_W     = 3,
  parameter int DATA_W    = 32,
  parameter int REG_W     = 5,
  parameter int CDB_PORTS = 2
) (
  input  logic                        clk1,
  input  logic                        rst,
  input  logic                        alloc_valid,
  input  logic [REG_W-1:0]            alloc_dest,
  output logic                        alloc_ready,
  output logic [TAG_W-1:0]            alloc_tag,
  input  logic [CDB_PORTS-1:0]        cdb_valid,
  input  logic [CDB_PORTS*TAG_W-1:0]  cdb_tag,
  input  logic [CDB_PORTS*DATA_W-1:0] cdb_data,
  output logic                        commit_valid,
  input  logic                        commit_ready,
  output logic [TAG_W-1:0]            commit_tag,
  output logic [REG_W-1:0]            commit_dest,
  output logic [DATA_W-1:0]           commit_data,
  input  logic [TAG_W-1:0]            rd_tag,
  output logic                        rd_ready,
  output logic [DATA_W-1:0]           rd_data,
  input  logic                        flush,
  output logic [TAG_W:0]              count,
  output logic                        empty,
  output logic                        full
);

  localparam logic [TAG_W-1:0] TAG_ZERO = {TAG_W{1'b0}};
  localparam logic [TAG_W-1:0] TAG_ONE  = TAG_W'(1);
  localparam logic [TAG_W:0]   CNT_ZERO = {(TAG_W+1){1'b0}};
  localparam logic [TAG_W:0]   CNT_ONE  = (TAG_W+1)'(1);
  localparam logic [TAG_W:0]   CNT_FULL = (TAG_W+1)'(ROB_DEPTH);

  // Entry storage
  logic              entry_valid [ROB_DEPTH];
  logic              entry_done  [ROB_DEPTH];
  logic [REG_W-1:0]  entry_dest  [ROB_DEPTH];
  logic [DATA_W-1:0] entry_data  [ROB_DEPTH];

  logic [TAG_W-1:0]  head;
  logic [TAG_W-1:0]  tail;
  logic [TAG_W:0]    occ;

  // Per-entry view of this cycle's CDB traffic, already resolved by port priority
  logic              cdb_hit   [ROB_DEPTH];
  logic [DATA_W-1:0] cdb_wdata [ROB_DEPTH];

  logic alloc_fire;
  logic commit_fire;

  assign full        = (occ == CNT_FULL);
  assign empty       = (occ == CNT_ZERO);
  assign count       = occ;
  assign alloc_ready = !full;
  assign alloc_tag   = tail;

  // A full ROB refuses allocation even if the head retires this same cycle.
  assign alloc_fire  = alloc_valid && !full;

  assign commit_valid = entry_valid[head] && entry_done[head];
  assign commit_tag   = head;
  assign commit_dest  = entry_dest[head];
  assign commit_data  = entry_data[head];
  assign commit_fire  = commit_valid && commit_ready;

  // Resolve CDB ports onto entries; ports are scanned high to low so the
  // lowest-numbered port matching a tag overrides the others.
  always_comb begin
    for (int i = 0; i < ROB_DEPTH; i++) begin
      cdb_hit[i]   = 1'b0;
      cdb_wdata[i] = {DATA_W{1'b0}};
      for (int p = CDB_PORTS - 1; p >= 0; p--) begin
        if (cdb_valid[p] && (cdb_tag[p*TAG_W +: TAG_W] == TAG_W'(i))) begin
          cdb_hit[i]   = 1'b1;
          cdb_wdata[i] = cdb_data[p*DATA_W +: DATA_W];
        end else begin
          cdb_hit[i]   = cdb_hit[i];
          cdb_wdata[i] = cdb_wdata[i];
        end
      end
    end
  end

  // Operand lookup port, optionally bypassing a same-cycle CDB result
  always_comb begin
    rd_ready = entry_valid[rd_tag] && entry_done[rd_tag];
    rd_data  = entry_data[rd_tag];
`ifdef CDB_BYPASS_EN
    if (cdb_hit[rd_tag] && entry_valid[rd_tag] && !entry_done[rd_tag]) begin
      rd_ready = 1'b1;
      rd_data  = cdb_wdata[rd_tag];
    end else begin
      rd_ready = rd_ready;
      rd_data  = rd_data;
    end
`endif
  end

  // Entry state, pointers and occupancy; reset and flush clear everything.
  // Commit and allocate never touch the same slot: head==tail with entries
  // in flight only happens when full, and then allocation is refused.
  always_ff @(posedge clk1) begin
    if (rst || flush) begin
      for (int i = 0; i < ROB_DEPTH; i++) begin
        entry_valid[i] <= 1'b0;
        entry_done[i]  <= 1'b0;
        entry_dest[i]  <= {REG_W{1'b0}};
        entry_data[i]  <= {DATA_W{1'b0}};
      end
      head <= TAG_ZERO;
      tail <= TAG_ZERO;
      occ  <= CNT_ZERO;
    end else begin
      // Completion: only valid, not-yet-done entries accept a result. A
      // committing head is already done, so it never takes a write here.
      for (int i = 0; i < ROB_DEPTH; i++) begin
        if (cdb_hit[i] && entry_valid[i] && !entry_done[i]) begin
          entry_done[i] <= 1'b1;
          entry_data[i] <= cdb_wdata[i];
        end
      end

      if (commit_fire) begin
        entry_valid[head] <= 1'b0;
        entry_done[head]  <= 1'b0;
        head              <= head + TAG_ONE;
      end

      if (alloc_fire) begin
        entry_valid[tail] <= 1'b1;
        entry_done[tail]  <= 1'b0;
        entry_dest[tail]  <= alloc_dest;
        tail              <= tail + TAG_ONE;
      end

      case ({alloc_fire, commit_fire})
        2'b10:   occ <= occ + CNT_ONE;
        2'b01:   occ <= occ - CNT_ONE;
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: tb/tb_tomasulo_rob.sv
// -----------------------------------------------------------------------------
// tb_tomasulo_rob -- self-checking bench for tomasulo_rob (default parameters).
// A behavioural model keeps a queue of allocated tags in program order; every
// commit handshake pops that queue and compares tag/dest/data.
// -----------------------------------------------------------------------------
module tb_tomasulo_rob;

  logic        clk1 = 1'b0;
  logic        rst;
  logic        alloc_valid;
  logic [4:0]  alloc_dest;
  logic        alloc_ready;
  logic [2:0]  alloc_tag;
  logic [1:0]  cdb_valid;
  logic [5:0]  cdb_tag;
  logic [63:0] cdb_data;
  logic        commit_valid;
  logic        commit_ready;
  logic [2:0]  commit_tag;
  logic [4:0]  commit_dest;
  logic [31:0] commit_data;
  logic [2:0]  rd_tag;
  logic        rd_ready;
  logic [31:0] rd_data;
  logic        flush;
  logic [3:0]  count;
  logic        empty;
  logic        full;

  int total = 0;
  int bad   = 0;

  // model
  logic [2:0]  q[$];
  bit          mvalid [8];
  bit          mdone  [8];
  logic [4:0]  mdest  [8];
  logic [31:0] mdata  [8];
  int          mcount;
  logic [2:0]  mtail;

  tomasulo_rob dut (
    .clk1(clk1), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_dest(alloc_dest),
    .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .commit_valid(commit_valid), .commit_ready(commit_ready),
    .commit_tag(commit_tag), .commit_dest(commit_dest), .commit_data(commit_data),
    .rd_tag(rd_tag), .rd_ready(rd_ready), .rd_data(rd_data),
    .flush(flush), .count(count), .empty(empty), .full(full)
  );

  always #5 clk1 = ~clk1;

  // Check the commit port against the model, advance the model, then clock.
  task automatic tick();
    bit          cv_e, cfire, afire;
    bit          nset [8];
    logic [31:0] nval [8];
    logic [2:0]  t;
    cv_e = (q.size() > 0) && mvalid[q[0]] && mdone[q[0]];
    if (!rst && !flush) begin
      total++;
      if (commit_valid !== cv_e) begin
        bad++;
        $display("FAIL commit_valid got=%0b exp=%0b t=%0t", commit_valid, cv_e, $time);
      end
      if (cv_e && commit_ready) begin
        total++;
        if ({commit_tag, commit_dest, commit_data} !== {q[0], mdest[q[0]], mdata[q[0]]}) begin
          bad++;
          $display("FAIL commit_entry got=%0d/%0d/%h exp=%0d/%0d/%h", commit_tag, commit_dest,
                   commit_data, q[0], mdest[q[0]], mdata[q[0]]);
        end
      end
    end
    if (rst || flush) begin
      q.delete();
      for (int i = 0; i < 8; i++) begin
        mvalid[i] = 0; mdone[i] = 0; mdest[i] = '0; mdata[i] = '0;
      end
      mcount = 0;
      mtail  = '0;
    end else begin
      cfire = cv_e && commit_ready;
      afire = alloc_valid && (mcount < 8);
      for (int i = 0; i < 8; i++) begin nset[i] = 0; nval[i] = '0; end
      for (int p = 1; p >= 0; p--) begin
        t = cdb_tag[p*3 +: 3];
        if (cdb_valid[p] && mvalid[t] && !mdone[t]) begin
          nset[t] = 1; nval[t] = cdb_data[p*32 +: 32];
        end
      end
      for (int i = 0; i < 8; i++) begin
        if (nset[i]) begin mdone[i] = 1; mdata[i] = nval[i]; end
      end
      if (cfire) begin
        mvalid[q[0]] = 0; mdone[q[0]] = 0;
        void'(q.pop_front());
        mcount--;
      end
      if (afire) begin
        mvalid[mtail] = 1; mdone[mtail] = 0; mdest[mtail] = alloc_dest;
        q.push_back(mtail);
        mtail = mtail + 3'd1;
        mcount++;
      end
    end
    @(posedge clk1);
    #1;
  endtask

  task automatic idle_inputs();
    alloc_valid = 1'b0; alloc_dest = 5'd0; cdb_valid = 2'b00; cdb_tag = 6'd0;
    cdb_data = 64'd0; commit_ready = 1'b0; rd_tag = 3'd0; flush = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1; tick(); flush = 1'b0;
  endtask

  task automatic alloc_n(input int n, input int dest0);
    for (int i = 0; i < n; i++) begin
      alloc_valid = 1'b1; alloc_dest = 5'(dest0 + i); tick();
    end
    alloc_valid = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    total++;
    if ({alloc_ready, alloc_tag, commit_valid, commit_tag, commit_dest, commit_data,
         rd_ready, empty, full, count} !== {1'b1, 3'd0, 1'b0, 3'd0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b0, 4'd0}) begin
      bad++;
      $display("FAIL reset_state got ar=%0b at=%0d cv=%0b ct=%0d cd=%0d cdat=%h rr=%0b e=%0b f=%0b c=%0d",
               alloc_ready, alloc_tag, commit_valid, commit_tag, commit_dest, commit_data,
               rd_ready, empty, full, count);
    end
  endtask

  task automatic test_alloc_commit();
    alloc_valid = 1'b1; alloc_dest = 5'd3;
    total++;
    if (alloc_tag !== 3'd0) begin bad++; $display("FAIL first_tag got=%0d exp=0", alloc_tag); end
    tick(); alloc_valid = 1'b0;
    total++;
    if ({count, empty} !== {4'd1, 1'b0}) begin
      bad++; $display("FAIL alloc_one got count=%0d empty=%0b exp 1/0", count, empty);
    end
    cdb_valid = 2'b01; cdb_tag = 6'd0; cdb_data = 64'h2D; tick(); cdb_valid = 2'b00;
    total++;
    if ({commit_valid, commit_dest, commit_data} !== {1'b1, 5'd3, 32'h2D}) begin
      bad++; $display("FAIL commit_first got cv=%0b dest=%0d data=%h exp 1/3/2d",
                      commit_valid, commit_dest, commit_data);
    end
    commit_ready = 1'b1; tick(); commit_ready = 1'b0;
    total++;
    if ({count, empty} !== {4'd0, 1'b1}) begin
      bad++; $display("FAIL commit_drain got count=%0d empty=%0b exp 0/1", count, empty);
    end
  endtask

  task automatic test_full_wrap();
    int guard;
    do_flush();
    alloc_n(8, 0);
    total++;
    if ({full, alloc_ready, count, alloc_tag} !== {1'b1, 1'b0, 4'd8, 3'd0}) begin
      bad++; $display("FAIL fill got full=%0b ar=%0b count=%0d tag=%0d exp 1/0/8/0",
                      full, alloc_ready, count, alloc_tag);
    end
    alloc_valid = 1'b1; alloc_dest = 5'd31; tick(); alloc_valid = 1'b0;
    total++;
    if ({count, alloc_tag, full} !== {4'd8, 3'd0, 1'b1}) begin
      bad++; $display("FAIL ninth_alloc got count=%0d tag=%0d full=%0b exp 8/0/1", count, alloc_tag, full);
    end
    cdb_valid = 2'b01; cdb_tag = 6'd0; cdb_data = 64'h100; tick(); cdb_valid = 2'b00;
    // full + commit in one cycle: allocation still refused
    alloc_valid = 1'b1; commit_ready = 1'b1; tick(); alloc_valid = 1'b0; commit_ready = 1'b0;
    total++;
    if ({count, alloc_tag, alloc_ready} !== {4'd7, 3'd0, 1'b1}) begin
      bad++; $display("FAIL full_commit_alloc got count=%0d tag=%0d ar=%0b exp 7/0/1",
                      count, alloc_tag, alloc_ready);
    end
    for (int k = 1; k < 8; k++) begin
      cdb_valid = 2'b01; cdb_tag = 6'(k); cdb_data = 64'(32'h100 + k); tick();
    end
    cdb_valid = 2'b00; commit_ready = 1'b1;
    guard = 0;
    while (!empty && guard < 20) begin tick(); guard++; end
    commit_ready = 1'b0;
    total++;
    if (empty !== 1'b1) begin bad++; $display("FAIL drain_timeout got count=%0d exp 0", count); end
  endtask

  task automatic test_out_of_order();
    do_flush();
    alloc_n(3, 10);
    cdb_valid = 2'b01; cdb_tag = 6'd2; cdb_data = 64'hA2; tick();
    total++;
    if (commit_valid !== 1'b0) begin bad++; $display("FAIL ooo_tag2 got cv=%0b exp 0", commit_valid); end
    cdb_tag = 6'd1; cdb_data = 64'hA1; tick();
    total++;
    if (commit_valid !== 1'b0) begin bad++; $display("FAIL ooo_tag1 got cv=%0b exp 0", commit_valid); end
    // head write coincides with commit attempt: nothing retires this cycle
    cdb_tag = 6'd0; cdb_data = 64'hA0; commit_ready = 1'b1; tick(); cdb_valid = 2'b00;
    total++;
    if ({commit_valid, count, commit_tag} !== {1'b1, 4'd3, 3'd0}) begin
      bad++; $display("FAIL ooo_head got cv=%0b count=%0d tag=%0d exp 1/3/0", commit_valid, count, commit_tag);
    end
    tick();
    total++;
    if ({commit_valid, commit_tag, count} !== {1'b1, 3'd1, 4'd2}) begin
      bad++; $display("FAIL ooo_retire1 got cv=%0b tag=%0d count=%0d exp 1/1/2", commit_valid, commit_tag, count);
    end
    tick();
    total++;
    if ({commit_valid, commit_tag, count} !== {1'b1, 3'd2, 4'd1}) begin
      bad++; $display("FAIL ooo_retire2 got cv=%0b tag=%0d count=%0d exp 1/2/1", commit_valid, commit_tag, count);
    end
    tick(); commit_ready = 1'b0;
    total++;
    if ({empty, commit_valid} !== {1'b1, 1'b0}) begin
      bad++; $display("FAIL ooo_empty got empty=%0b cv=%0b exp 1/0", empty, commit_valid);
    end
  endtask

  task automatic test_cdb_conflict();
    do_flush();
    alloc_n(4, 20);
    cdb_valid = 2'b11; cdb_tag = {3'd1, 3'd1}; cdb_data = {32'h22, 32'h11}; tick();
    rd_tag = 3'd1; #1;
    total++;
    if ({rd_ready, rd_data} !== {1'b1, 32'h11}) begin
      bad++; $display("FAIL same_tag got rr=%0b data=%h exp 1/11", rd_ready, rd_data);
    end
    cdb_tag = {3'd3, 3'd2}; cdb_data = {32'h44, 32'h33}; tick();
    rd_tag = 3'd2; #1;
    total++;
    if ({rd_ready, rd_data} !== {1'b1, 32'h33}) begin
      bad++; $display("FAIL dual_tag2 got rr=%0b data=%h exp 1/33", rd_ready, rd_data);
    end
    rd_tag = 3'd3; #1;
    total++;
    if ({rd_ready, rd_data} !== {1'b1, 32'h44}) begin
      bad++; $display("FAIL dual_tag3 got rr=%0b data=%h exp 1/44", rd_ready, rd_data);
    end
    cdb_valid = 2'b10; cdb_tag = {3'd1, 3'd0}; cdb_data = {32'h99, 32'h0}; tick(); cdb_valid = 2'b00;
    rd_tag = 3'd1; #1;
    total++;
    if (rd_data !== 32'h11) begin bad++; $display("FAIL done_ignored got data=%h exp 11", rd_data); end
    rd_tag = 3'd0;
  endtask

  task automatic test_flush();
    do_flush();
    alloc_n(5, 1);
    flush = 1'b1; alloc_valid = 1'b1; alloc_dest = 5'd9;
    cdb_valid = 2'b01; cdb_tag = 6'd0; cdb_data = 64'h55; commit_ready = 1'b1;
    tick();
    idle_inputs();
    total++;
    if ({count, empty, alloc_tag, commit_valid, rd_ready} !== {4'd0, 1'b1, 3'd0, 1'b0, 1'b0}) begin
      bad++; $display("FAIL flush got count=%0d empty=%0b tag=%0d cv=%0b rr=%0b exp 0/1/0/0/0",
                      count, empty, alloc_tag, commit_valid, rd_ready);
    end
  endtask

  task automatic test_rd_bypass();
    bit exp_rr;
    do_flush();
    alloc_n(5, 2);
    rd_tag = 3'd4; cdb_valid = 2'b01; cdb_tag = 6'd4; cdb_data = 64'h7; #1;
`ifdef CDB_BYPASS_EN
    exp_rr = 1'b1;
`else
    exp_rr = 1'b0;
`endif
    total++;
    if (rd_ready !== exp_rr || (exp_rr && rd_data !== 32'h7)) begin
      bad++; $display("FAIL rd_same_cycle got rr=%0b data=%h exp rr=%0b", rd_ready, rd_data, exp_rr);
    end
    tick(); cdb_valid = 2'b00; #1;
    total++;
    if ({rd_ready, rd_data} !== {1'b1, 32'h7}) begin
      bad++; $display("FAIL rd_next_cycle got rr=%0b data=%h exp 1/7", rd_ready, rd_data);
    end
    do_flush();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_alloc_commit();
    test_full_wrap();
    test_out_of_order();
    test_cdb_conflict();
    test_flush();
    test_rd_bypass();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
